// File: rtl/data_sram_responder.sv
// Data SRAM responder: word RAM with 1-cycle read latency plus LED/NUM/timer config registers.
// Define DATA_SRAM_ERR_EN to flag unmapped RAM-region accesses (DEADBEEF read data, sticky bus_err).
module data_sram_responder #(
  parameter int unsigned ADDR_WIDTH = 12,
  parameter logic [31:0] CONF_BASE  = 32'hBFAF_0000,
  parameter logic [31:0] CONF_MASK  = 32'hFFFF_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic [15:0] led,
  output logic [31:0] num_data,
  output logic        timer_irq,
  output logic        bus_err
);

  localparam int unsigned DEPTH    = 1 << ADDR_WIDTH;
  localparam logic [11:0] OFF_LED   = 12'h000;
  localparam logic [11:0] OFF_NUM   = 12'h004;
  localparam logic [11:0] OFF_COUNT = 12'h008;
  localparam logic [11:0] OFF_CMP   = 12'h00C;
  localparam logic [11:0] OFF_CTRL  = 12'h010;

  logic [31:0] mem [DEPTH];

  logic [31:0] rdata_q, rdata_d;
  logic [15:0] led_q, led_d;
  logic [31:0] num_q, num_d;
  logic [31:0] count_q, count_d;
  logic [31:0] cmp_q, cmp_d;
  logic        tmr_en_q, tmr_en_d;
  logic        pend_q, pend_d;

  logic                  conf_hit_c, unmapped_c, rd_c, wr_c, ram_we_c;
  logic [ADDR_WIDTH-1:0] idx_c;
  logic [11:0]           off_c;
  logic [31:0]           conf_rdata_c;

  function automatic logic [31:0] merge_be(input logic [31:0] old_v, input logic [31:0] new_v,
                                           input logic [3:0] be);
    logic [31:0] res;
    for (int i = 0; i < 4; i++) begin
      res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    end
    return res;
  endfunction

  assign conf_hit_c = (data_sram_addr & CONF_MASK) == (CONF_BASE & CONF_MASK);
  assign idx_c      = data_sram_addr[ADDR_WIDTH+1:2];
  assign off_c      = data_sram_addr[11:0];
  assign rd_c       = data_sram_en && (data_sram_wen == 4'h0);
  assign wr_c       = data_sram_en && (data_sram_wen != 4'h0);
`ifdef DATA_SRAM_ERR_EN
  assign unmapped_c = !conf_hit_c && (|data_sram_addr[31:ADDR_WIDTH+2]);
`else
  assign unmapped_c = 1'b0;
`endif
  // A write coinciding with reset assertion must not land in the RAM.
  assign ram_we_c   = rst && wr_c && !conf_hit_c && !unmapped_c;

  always_ff @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (ram_we_c && data_sram_wen[i]) begin
        mem[idx_c][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  // Config register read mux; COUNT returns its pre-increment value.
  always_comb begin
    conf_rdata_c = 32'h0;
    case (off_c)
      OFF_LED:   conf_rdata_c = {16'h0, led_q};
      OFF_NUM:   conf_rdata_c = num_q;
      OFF_COUNT: conf_rdata_c = count_q;
      OFF_CMP:   conf_rdata_c = cmp_q;
      OFF_CTRL:  conf_rdata_c = {30'h0, pend_q, tmr_en_q};
      default:   conf_rdata_c = 32'h0;
    endcase
  end

  always_comb begin
    rdata_d  = rdata_q;
    led_d    = led_q;
    num_d    = num_q;
    count_d  = tmr_en_q ? count_q + 32'd1 : count_q;
    cmp_d    = cmp_q;
    tmr_en_d = tmr_en_q;
    pend_d   = pend_q;

    if (rd_c) begin
      if (conf_hit_c)      rdata_d = conf_rdata_c;
      else if (unmapped_c) rdata_d = 32'hDEAD_BEEF;
      else                 rdata_d = mem[idx_c];
    end

    if (wr_c && conf_hit_c) begin
      case (off_c)
        OFF_LED: begin
          if (data_sram_wen[0]) led_d[7:0]  = data_sram_wdata[7:0];
          if (data_sram_wen[1]) led_d[15:8] = data_sram_wdata[15:8];
        end
        OFF_NUM:   num_d   = merge_be(num_q, data_sram_wdata, data_sram_wen);
        OFF_COUNT: count_d = merge_be(count_q, data_sram_wdata, data_sram_wen);
        OFF_CMP:   cmp_d   = merge_be(cmp_q, data_sram_wdata, data_sram_wen);
        OFF_CTRL: begin
          if (data_sram_wen[0]) begin
            tmr_en_d = data_sram_wdata[0];
            if (data_sram_wdata[1]) pend_d = 1'b0;
          end
        end
        default: ;
      endcase
    end

    // Compare set overrides a same-cycle W1C.
    if (tmr_en_q && (count_q == cmp_q)) pend_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdata_q  <= 32'h0;
      led_q    <= 16'h0;
      num_q    <= 32'h0;
      count_q  <= 32'h0;
      cmp_q    <= 32'hFFFF_FFFF;
      tmr_en_q <= 1'b0;
      pend_q   <= 1'b0;
    end else begin
      rdata_q  <= rdata_d;
      led_q    <= led_d;
      num_q    <= num_d;
      count_q  <= count_d;
      cmp_q    <= cmp_d;
      tmr_en_q <= tmr_en_d;
      pend_q   <= pend_d;
    end
  end

`ifdef DATA_SRAM_ERR_EN
  logic bus_err_q, bus_err_d;

  always_comb begin
    bus_err_d = bus_err_q;
    if (data_sram_en && unmapped_c) bus_err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) bus_err_q <= 1'b0;
    else      bus_err_q <= bus_err_d;
  end

  assign bus_err = bus_err_q;
`else
  assign bus_err = 1'b0;
`endif

  assign data_sram_rdata = rdata_q;
  assign led             = led_q;
  assign num_data        = num_q;
  assign timer_irq       = pend_q;

endmodule

// File: tb/tb_data_sram_responder.sv
// Scoreboard bench for data_sram_responder: directed scenarios plus random traffic vs a behavioural model.
`timescale 1ns/1ps
module tb_data_sram_responder;

  localparam logic [31:0] CONF_BASE = 32'hBFAF_0000;
  localparam logic [31:0] CONF_MASK = 32'hFFFF_0000;
`ifdef DATA_SRAM_ERR_EN
  localparam bit ERR = 1'b1;
`else
  localparam bit ERR = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic [3:0]  wen;
  logic [31:0] addr, wdata;
  logic [31:0] rdata;
  logic [15:0] led;
  logic [31:0] num_data;
  logic        timer_irq, bus_err;

  always #5 clk = ~clk;

  data_sram_responder dut (
    .clk(clk), .rst(rst),
    .data_sram_en(en), .data_sram_wen(wen), .data_sram_addr(addr), .data_sram_wdata(wdata),
    .data_sram_rdata(rdata), .led(led), .num_data(num_data),
    .timer_irq(timer_irq), .bus_err(bus_err)
  );

  typedef struct {
    logic [31:0] rdata;
    logic [15:0] led;
    logic [31:0] num;
    logic        irq;
    logic        berr;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model state
  logic [31:0] m_ram [int unsigned];
  logic [31:0] m_rdata, m_num, m_count, m_cmp;
  logic [15:0] m_led;
  logic        m_en, m_pend, m_berr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] d,
                                        input logic [3:0] w);
    logic [31:0] r = old_v;
    for (int i = 0; i < 4; i++) if (w[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  task automatic model_reset();
    m_rdata = 32'h0; m_led = 16'h0; m_num = 32'h0; m_count = 32'h0;
    m_cmp = 32'hFFFF_FFFF; m_en = 1'b0; m_pend = 1'b0; m_berr = 1'b0;
  endtask

  task automatic model_step(input logic e, input logic [3:0] w, input logic [31:0] a,
                            input logic [31:0] d);
    exp_t        x;
    logic        conf = (a & CONF_MASK) == (CONF_BASE & CONF_MASK);
    int unsigned wi   = 32'(a[13:2]);
    bit          unm  = ERR && !conf && (a[31:14] != 18'h0);
    bit          hit  = m_en && (m_count == m_cmp);
    logic [31:0] nc   = m_en ? m_count + 32'd1 : m_count;
    logic        np   = m_pend;
    logic        ne   = m_en;
    logic [31:0] tmp;
    if (e && w == 4'h0) begin
      if (conf) begin
        case (a[11:0])
          12'h000: m_rdata = {16'h0, m_led};
          12'h004: m_rdata = m_num;
          12'h008: m_rdata = m_count;
          12'h00C: m_rdata = m_cmp;
          12'h010: m_rdata = {30'h0, m_pend, m_en};
          default: m_rdata = 32'h0;
        endcase
      end else if (unm) m_rdata = 32'hDEAD_BEEF;
      else m_rdata = m_ram.exists(wi) ? m_ram[wi] : 32'h0;
    end else if (e) begin
      if (conf) begin
        case (a[11:0])
          12'h000: begin tmp = lanes({16'h0, m_led}, d, w); m_led = tmp[15:0]; end
          12'h004: m_num = lanes(m_num, d, w);
          12'h008: nc = lanes(m_count, d, w);
          12'h00C: m_cmp = lanes(m_cmp, d, w);
          12'h010: if (w[0]) begin ne = d[0]; if (d[1]) np = 1'b0; end
          default: ;
        endcase
      end else if (!unm) begin
        m_ram[wi] = lanes(m_ram.exists(wi) ? m_ram[wi] : 32'h0, d, w);
      end
    end
    if (e && unm) m_berr = 1'b1;
    if (hit) np = 1'b1;
    m_count = nc; m_pend = np; m_en = ne;
    x.rdata = m_rdata; x.led = m_led; x.num = m_num; x.irq = m_pend; x.berr = m_berr;
    exp_q.push_back(x);
  endtask

  // One bus cycle: drive on the falling edge, predict the state after the next rising edge.
  task automatic cyc(input logic e, input logic [3:0] w, input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    en = e; wen = w; addr = a; wdata = d;
    model_step(e, w, a, d);
  endtask

  task automatic idle();
    cyc(1'b0, 4'($urandom), $urandom, $urandom);
  endtask

  task automatic settle();
    @(posedge clk);
    #2;
  endtask

  task automatic drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 20) begin
      @(posedge clk);
      #2;
      k++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL drain: %0d expected responses never observed", exp_q.size());
      exp_q.delete();
    end
  endtask

  // Monitor: every cycle with a prediction outstanding, compare all observable outputs.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      check("rdata", rdata, mon_e.rdata);
      check("led", {16'h0, led}, {16'h0, mon_e.led});
      check("num_data", num_data, mon_e.num);
      check("timer_irq", 32'(timer_irq), 32'(mon_e.irq));
      check("bus_err", 32'(bus_err), 32'(mon_e.berr));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    logic [3:0]  w;
    int          r;
    rst = 1'b0; en = 1'b0; wen = 4'h0; addr = 32'h0; wdata = 32'h0;
    model_reset();
    #2;
    check("reset_rdata", rdata, 32'h0);
    check("reset_led", {16'h0, led}, 32'h0);
    check("reset_num", num_data, 32'h0);
    check("reset_irq", 32'(timer_irq), 32'h0);
    check("reset_bus_err", 32'(bus_err), 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;

    // Full-word write then read; held while idle
    cyc(1'b1, 4'hF, 32'h0000_0040, 32'h1234_5678);
    cyc(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    settle();
    check("t1_read", rdata, 32'h1234_5678);
    idle();
    idle();
    settle();
    check("t1_hold", rdata, 32'h1234_5678);

    // Single-lane write, back-to-back read of the merged word
    cyc(1'b1, 4'b0010, 32'h0000_0040, 32'hFFFF_ABFF);
    cyc(1'b1, 4'h0, 32'h0000_0040, 32'h0);
    settle();
    check("t2_merge", rdata, 32'h1234_AB78);

    // LED register and an unmapped config offset
    cyc(1'b1, 4'hF, CONF_BASE, 32'h0000_A5A5);
    settle();
    check("t3_led", {16'h0, led}, 32'h0000_A5A5);
    cyc(1'b1, 4'h0, CONF_BASE + 32'h14, 32'h0);
    settle();
    check("t3_conf_hole", rdata, 32'h0);

    // Known contents for the random-traffic RAM pool
    for (int i = 0; i < 16; i++) cyc(1'b1, 4'hF, 32'(i * 4), $urandom);
    cyc(1'b1, 4'hF, 32'h0000_0080, 32'hCAFE_0080);

    // Timer compare, interrupt, W1C, wrap
    cyc(1'b1, 4'hF, CONF_BASE + 32'h08, 32'h0);
    cyc(1'b1, 4'hF, CONF_BASE + 32'h0C, 32'd10);
    cyc(1'b1, 4'hF, CONF_BASE + 32'h10, 32'h1);
    for (int i = 0; i < 11; i++) idle();
    settle();
    check("t4_irq_latency", 32'(timer_irq), 32'h1);
    cyc(1'b1, 4'h1, CONF_BASE + 32'h10, 32'h3);
    settle();
    check("t4_w1c", 32'(timer_irq), 32'h0);
    cyc(1'b1, 4'hF, CONF_BASE + 32'h0C, 32'd5);
    cyc(1'b1, 4'hF, CONF_BASE + 32'h08, 32'hFFFF_FFFE);
    idle();
    idle();
    cyc(1'b1, 4'h0, CONF_BASE + 32'h08, 32'h0);
    settle();
    check("t4_wrap", rdata, 32'h0);

    // Random traffic
    for (int n = 0; n < 400; n++) begin
      r = $urandom_range(0, 9);
      w = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      if (r < 5)      a = 32'($urandom_range(0, 15) * 4) | 32'($urandom_range(0, 3));
      else if (r < 7) a = CONF_BASE + 32'($urandom_range(0, 6) * 4);
      else if (r < 8) a = 32'h0001_0000 | 32'($urandom_range(0, 15) * 4);
      else            a = $urandom;
      if (r < 8) cyc(1'b1, w, a, $urandom);
      else       cyc(1'b0, w, a, $urandom);
    end

    // Asynchronous reset landing on a write cycle
    drain();
    @(negedge clk);
    en = 1'b1; wen = 4'hF; addr = 32'h0000_0080; wdata = 32'hFFFF_FFFF;
    #1 rst = 1'b0;
    #1;
    check("t5_rdata", rdata, 32'h0);
    check("t5_led", {16'h0, led}, 32'h0);
    check("t5_num", num_data, 32'h0);
    check("t5_irq", 32'(timer_irq), 32'h0);
    check("t5_bus_err", 32'(bus_err), 32'h0);
    @(negedge clk);
    en = 1'b0;
    rst = 1'b1;
    model_reset();
    cyc(1'b1, 4'h0, 32'h0000_0080, 32'h0);
    settle();
    check("t5_ram_kept", rdata, 32'hCAFE_0080);
    cyc(1'b1, 4'h0, CONF_BASE + 32'h0C, 32'h0);
    settle();
    check("t5_cmp", rdata, 32'hFFFF_FFFF);

    // Out-of-range RAM address
    cyc(1'b1, 4'h0, 32'h0001_0000, 32'h0);
    settle();
`ifdef DATA_SRAM_ERR_EN
    check("t6_deadbeef", rdata, 32'hDEAD_BEEF);
    check("t6_bus_err", 32'(bus_err), 32'h1);
    idle();
    idle();
    settle();
    check("t6_bus_err_sticky", 32'(bus_err), 32'h1);
`else
    check("t6_alias", rdata, m_ram[0]);
    check("t6_bus_err", 32'(bus_err), 32'h0);
`endif

    idle();
    drain();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
